// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that shares one memory request port between requesters.
// An in-order tag FIFO steers each response back to the requester that issued it.
module mem_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int MAX_OUT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_we,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic [DATA_W-1:0]         mem_req_wdata,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_W-1:0]         mem_rsp_rdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [$clog2(MAX_OUT):0]  outstanding,
    output logic                      err_unexp_rsp
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_found;
    logic [IDX_W:0]   cand;
    logic             stage_free;
    logic             can_grant;
    logic             accept;
    logic             pop;

    logic [IDX_W-1:0] tag_mem [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Search from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!gnt_found && req_valid[cand[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // A same-cycle pop is deliberately not credited when full.
    assign stage_free = !mem_req_valid || mem_req_ready;
    assign can_grant  = stage_free && (outstanding < CNT_W'(MAX_OUT));
    assign accept     = can_grant && gnt_found;
    assign req_ready  = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign pop        = mem_rsp_valid && (outstanding != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            rr_ptr        <= '0;
        end else if (accept) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= req_we[gnt_idx];
            mem_req_addr  <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            mem_req_wdata <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
            rr_ptr        <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0
                             : gnt_idx + IDX_W'(1);
        end else if (stage_free) begin
            mem_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            tag_mem[wr_ptr] <= gnt_idx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outstanding   <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({accept, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            rsp_valid <= pop ? (NUM_REQ'(1) << tag_mem[rd_ptr]) : '0;
            if (pop)
                rsp_rdata <= mem_rsp_rdata;
            if (mem_rsp_valid && !pop)
                err_unexp_rsp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter.
// Response expectations flow through a scoreboard queue checked by a monitor.
module tb_mem_req_arbiter;
    typedef struct packed {
        logic [3:0]  oh;
        logic [63:0] d;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [3:0]   req_we;
    logic [127:0] req_addr;
    logic [255:0] req_wdata;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_we;
    logic [31:0]  mem_req_addr;
    logic [63:0]  mem_req_wdata;
    logic         mem_rsp_valid;
    logic [63:0]  mem_rsp_rdata;
    logic [3:0]   rsp_valid;
    logic [63:0]  rsp_rdata;
    logic [3:0]   outstanding;
    logic         err_unexp_rsp;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    mem_req_arbiter #(
        .NUM_REQ(4), .ADDR_W(32), .DATA_W(64), .MAX_OUT(8)
    ) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .outstanding(outstanding), .err_unexp_rsp(err_unexp_rsp)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    // Monitor: every response strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid !== 4'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got rsp_valid=%b required none", rsp_valid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_valid !== e.oh || rsp_rdata !== e.d) begin
                    errors++;
                    $display("FAIL sb_rsp: got %b/%h required %b/%h",
                             rsp_valid, rsp_rdata, e.oh, e.d);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] a,
                           input logic [63:0] d);
        req_we[i]            = we;
        req_addr[i*32 +: 32] = a;
        req_wdata[i*64 +: 64] = d;
    endtask

    task automatic send_rsp(input logic [3:0] oh, input logic [63:0] d);
        cyc();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = d;
        sb.push_back('{oh: oh, d: d});
        @(negedge clk);
    endtask

    task automatic end_rsp();
        cyc();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req_valid, req_ready, outstanding, err_unexp_rsp, rsp_valid}
            !== 14'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b rdy=%b out=%0d err=%b rsp=%b required zeros",
                     mem_req_valid, req_ready, outstanding, err_unexp_rsp, rsp_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fairness();
        logic [3:0] exp_oh;
        for (int i = 0; i < 4; i++)
            set_req(i, 1'b0, 32'h1000 + 32'(i * 16), 64'h0);
        cyc();
        mem_req_ready = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_oh = 4'b1 << (k % 4);
            checks++;
            if (req_ready !== exp_oh) begin
                errors++;
                $display("FAIL fair_grant%0d: got %b required %b", k, req_ready, exp_oh);
            end
            if (k > 0) begin
                checks++;
                if (mem_req_addr !== 32'h1000 + 32'(((k - 1) % 4) * 16)) begin
                    errors++;
                    $display("FAIL fair_addr%0d: got %h required %h", k, mem_req_addr,
                             32'h1000 + 32'(((k - 1) % 4) * 16));
                end
            end
            cyc();
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0 || outstanding !== 4'd8 || mem_req_addr !== 32'h1030) begin
            errors++;
            $display("FAIL fair_full: got rdy=%b out=%0d addr=%h required 0000/8/1030",
                     req_ready, outstanding, mem_req_addr);
        end
        req_valid = '0;
        for (int k = 0; k < 8; k++)
            send_rsp(4'b1 << (k % 4), 64'h100 + 64'(k));
        end_rsp();
        checks++;
        if (outstanding !== 4'd0) begin
            errors++;
            $display("FAIL fair_drain: got %0d required 0", outstanding);
        end
    endtask

    task automatic test_routing();
        cyc();
        set_req(2, 1'b0, 32'h100, 64'h0);
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL route_gnt2: got %b required 0100", req_ready);
        end
        cyc();
        set_req(0, 1'b1, 32'h200, 64'hDEAD);
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001 || mem_req_addr !== 32'h100 || mem_req_we !== 1'b0
            || mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL route_req2: got rdy=%b addr=%h we=%b v=%b required 0001/100/0/1",
                     req_ready, mem_req_addr, mem_req_we, mem_req_valid);
        end
        cyc();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (mem_req_addr !== 32'h200 || mem_req_we !== 1'b1
            || mem_req_wdata !== 64'hDEAD || outstanding !== 4'd2) begin
            errors++;
            $display("FAIL route_req0: got addr=%h we=%b wd=%h out=%0d required 200/1/dead/2",
                     mem_req_addr, mem_req_we, mem_req_wdata, outstanding);
        end
        send_rsp(4'b0100, 64'hAAAA);
        send_rsp(4'b0001, 64'h0);
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_rdata !== 64'hAAAA) begin
            errors++;
            $display("FAIL route_rsp1: got %b/%h required 0100/aaaa", rsp_valid, rsp_rdata);
        end
        cyc();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001) begin
            errors++;
            $display("FAIL route_rsp2: got %b required 0001", rsp_valid);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL route_idle: got rsp=%b out=%0d required 0000/0", rsp_valid, outstanding);
        end
    endtask

    task automatic test_backpressure();
        cyc();
        mem_req_ready = 1'b0;
        set_req(1, 1'b0, 32'h300, 64'h0);
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_first: got %b required 0010", req_ready);
        end
        for (int k = 0; k < 5; k++) begin
            cyc();
            set_req(1, 1'b0, 32'h304, 64'h0);
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300) begin
                errors++;
                $display("FAIL bp_hold%0d: got rdy=%b v=%b addr=%h required 0000/1/300",
                         k, req_ready, mem_req_valid, mem_req_addr);
            end
        end
        cyc();
        mem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_resume: got %b required 0010", req_ready);
        end
        cyc();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (mem_req_addr !== 32'h304 || outstanding !== 4'd2) begin
            errors++;
            $display("FAIL bp_next: got addr=%h out=%0d required 304/2", mem_req_addr, outstanding);
        end
        send_rsp(4'b0010, 64'h11);
        send_rsp(4'b0010, 64'h22);
        end_rsp();
    endtask

    task automatic test_full_pop();
        cyc();
        set_req(3, 1'b0, 32'h400, 64'h0);
        req_valid = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b1000) begin
                errors++;
                $display("FAIL full_fill%0d: got %b required 1000", k, req_ready);
            end
            cyc();
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h55;
        sb.push_back('{oh: 4'b1000, d: 64'h55});
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0 || outstanding !== 4'd8) begin
            errors++;
            $display("FAIL full_pop_nogrant: got rdy=%b out=%0d required 0000/8",
                     req_ready, outstanding);
        end
        cyc();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000 || outstanding !== 4'd7) begin
            errors++;
            $display("FAIL full_resume: got rdy=%b out=%0d required 1000/7",
                     req_ready, outstanding);
        end
        cyc();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (outstanding !== 4'd8) begin
            errors++;
            $display("FAIL full_cap: got %0d required 8", outstanding);
        end
        for (int k = 0; k < 8; k++)
            send_rsp(4'b1000, 64'h60 + 64'(k));
        end_rsp();
        checks++;
        if (outstanding !== 4'd0) begin
            errors++;
            $display("FAIL full_drain: got %0d required 0", outstanding);
        end
    endtask

    task automatic test_unexp();
        cyc();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hBAD;
        cyc();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0 || err_unexp_rsp !== 1'b1 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL unexp_rsp: got rsp=%b err=%b out=%0d required 0000/1/0",
                     rsp_valid, err_unexp_rsp, outstanding);
        end
        repeat (3) cyc();
        @(negedge clk);
        checks++;
        if (err_unexp_rsp !== 1'b1) begin
            errors++;
            $display("FAIL unexp_sticky: got %b required 1", err_unexp_rsp);
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        set_req(0, 1'b1, 32'h500, 64'h77);
        req_valid = 4'b0001;
        repeat (3) cyc();
        req_valid = '0;
        mem_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding !== 4'd3 || mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got out=%0d v=%b required 3/1", outstanding, mem_req_valid);
        end
        cyc();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, rsp_valid,
             rsp_rdata, outstanding, err_unexp_rsp, req_ready} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b addr=%h wd=%h out=%0d err=%b required zeros",
                     mem_req_valid, mem_req_addr, mem_req_wdata, outstanding, err_unexp_rsp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h99;
        cyc();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err_unexp_rsp !== 1'b1 || rsp_valid !== 4'b0) begin
            errors++;
            $display("FAIL mid_stray: got err=%b rsp=%b required 1/0000",
                     err_unexp_rsp, rsp_valid);
        end
        cyc();
        mem_req_ready = 1'b1;
        set_req(2, 1'b0, 32'h600, 64'h0);
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL mid_first_gnt: got %b required 0100", req_ready);
        end
        cyc();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (mem_req_addr !== 32'h600 || outstanding !== 4'd1) begin
            errors++;
            $display("FAIL mid_req: got addr=%h out=%0d required 600/1", mem_req_addr, outstanding);
        end
        send_rsp(4'b0100, 64'h1234);
        end_rsp();
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_routing();
        test_backpressure();
        test_full_pop();
        test_unexp();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Round-robin arbiter that shares the single memory-controller request port between `NUM_REQ` requesters (vector lanes, scalar load/store, fetch). It registers the winning request toward the memory controller and records the winner's index in an in-order tag FIFO. Each memory response is steered back to the requester that issued the oldest outstanding request. It sits between the core's memory clients and the memory controller.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8)
- `ADDR_W`, 32: address width
- `DATA_W`, 64: data width
- `MAX_OUT`, 8: maximum outstanding requests (power of two, ≥2)

- `clk`  in  1  clock; all logic is rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  per-requester accept (one-hot or zero)
- `req_we`  in  NUM_REQ  per-requester write enable
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data
- `mem_req_valid`  out  1  request to memory controller valid
- `mem_req_ready`  in  1  memory controller accepts
- `mem_req_we`, `mem_req_addr`, `mem_req_wdata`  out  1/ADDR_W/DATA_W  registered winning request
- `mem_rsp_valid`  in  1  response valid (always accepted)
- `mem_rsp_rdata`  in  DATA_W  response data (don't-care for writes)
- `rsp_valid`  out  NUM_REQ  one-hot response strobe to the owning requester
- `rsp_rdata`  out  DATA_W  response data, broadcast to all requesters
- `outstanding`  out  $clog2(MAX_OUT)+1  number of requests accepted whose responses have not yet returned
- `err_unexp_rsp`  out  1  sticky: a response arrived with no outstanding request

## Operation
- Out-register: `mem_req_*` form a single register stage. The stage is free when `!mem_req_valid || mem_req_ready`.
- Grant is asserted only when the out-register is free and `outstanding + pending_push < MAX_OUT`. A pop in the same cycle is not credited. Grant is combinational: the first requester with `req_valid` set, searching from `rr_ptr` upward with wrap. `req_ready[i]` is set for that requester only.
- Accept (`req_valid[i] && req_ready[i]`) has these effects:
  - Loads the out-register with requester i's fields and sets `mem_req_valid`.
  - Pushes i into the tag FIFO. The FIFO has depth MAX_OUT; its pointers are $clog2(MAX_OUT) bits and wrap.
  - Sets `rr_ptr` to (i+1) mod NUM_REQ.
- If the out-register is free and there is no accept, `mem_req_valid` is cleared.
- Every request, read or write, yields exactly one in-order response.
- On `mem_rsp_valid`:
  - If the FIFO is non-empty, pop the head h. Next cycle, `rsp_valid` = one-hot(h) and `rsp_rdata` = `mem_rsp_rdata`.
  - If the FIFO is empty, drop the response, set `err_unexp_rsp` (cleared only by reset), and leave `rsp_valid` at 0.
- `outstanding` increments on accept and decrements on a valid pop. Both in one cycle leave it unchanged.
- Reset, asynchronous, including mid-transfer:
  - All outputs go to 0.
  - `rr_ptr` = 0, FIFO empty, `outstanding` = 0.
  - In-flight requests and tags are discarded. Responses arriving after reset set `err_unexp_rsp`.

## Timing
- Request latency: accept in cycle N gives `mem_req_valid` in N+1. Back-to-back accepts are allowed every cycle while `mem_req_ready` = 1.
- Backpressure: while `mem_req_valid && !mem_req_ready`, `req_ready` = 0 and `mem_req_*` hold stable.
- Response latency: `mem_rsp_valid` in cycle M gives `rsp_valid` in M+1, pulsed for one cycle.
- Full: at `outstanding == MAX_OUT`, no grant, even if a response pops in that cycle. Grant resumes the cycle after the pop.
- `req_ready` depends combinationally on `req_valid`, `mem_req_ready`, and state. Requesters must not make `req_valid` depend on `req_ready`.

## Test plan
- **Fairness:** all 4 `req_valid` held high, `mem_req_ready` = 1, no responses, MAX_OUT = 8 → grants 0,1,2,3,0,1,2,3. `req_ready` then drops once `outstanding` = 8.
- **Routing:** requester 2 reads 0x100, then requester 0 writes 0x200 with data 0xDEAD. Memory returns 0xAAAA, then 0x0 → `rsp_valid` = 4'b0100 with data 0xAAAA, then 4'b0001. `outstanding` returns to 0.
- **Backpressure:** `mem_req_ready` = 0 for 5 cycles with requester 1 valid → one accept, then `req_ready` = 0. `mem_req_addr` is stable for 5 cycles and the next grant comes in the cycle `mem_req_ready` rises.
- **Full plus simultaneous pop:** `outstanding` = 8 and `mem_rsp_valid` = 1 with requester 3 valid → no grant that cycle, grant the next cycle, `outstanding` stays ≤ 8.
- **Unexpected response:** `mem_rsp_valid` with FIFO empty → `rsp_valid` = 0, `err_unexp_rsp` = 1 and held until reset.
- **Reset mid-operation:** assert `reset` low with 3 outstanding and `mem_req_valid` = 1 → all outputs 0 immediately and `outstanding` = 0. After release, requester 2 alone is granted first, and a stray response sets `err_unexp_rsp`.
